// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin resource arbiter.
package rr_arb_pkg;

  localparam int unsigned N_DEF        = 4;
  localparam int unsigned MAX_HOLD_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_GAP   = 2'b10
  } arb_state_e;

endpackage

// File: rtl/rr_resource_arbiter_pick.sv
// rr_pick: combinational rotating-priority search, first requester at or after ptr.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic                 any_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic [N-1:0]         onehot_o
);

  localparam int unsigned IW = $clog2(N);

  // Walk ptr, ptr+1, ... with wrap at N; the first hit wins.
  always_comb begin
    any_o    = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned   j;
      logic [IW-1:0] jj;
      j = 32'(ptr_i) + k;
      if (j >= N) begin
        j = j - N;
      end
      jj = IW'(j);
      if (!any_o && req_i[jj]) begin
        any_o        = 1'b1;
        idx_o        = jj;
        onehot_o[jj] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter for one single-user resource.
// Optional grant hold timeout compiled in with `define RR_ARB_TIMEOUT_EN.
module rr_resource_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned N        = N_DEF,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 timeout
);

  localparam int unsigned IW = $clog2(N);

  if (N < 2 || N > 8) begin : g_bad_n
    $error("rr_resource_arbiter: N must be 2..8");
  end
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("rr_resource_arbiter: MAX_HOLD must be >= 2");
  end

  arb_state_e    state_q;
  logic [N-1:0]  grant_q;
  logic [IW-1:0] grant_id_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic          busy_q;

  logic          pick_any;
  logic [IW-1:0] pick_idx;
  logic [N-1:0]  pick_onehot;

  logic          release_c;
  logic          expire_c;

  rr_pick #(.N(N)) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .any_o    (pick_any),
    .idx_o    (pick_idx),
    .onehot_o (pick_onehot)
  );

  // Owner releases by done or by dropping its own request; ptr moves past it.
  always_comb begin
    release_c = done || ((grant_q & req) == '0);
    ptr_d     = (grant_id_q == IW'(N - 1)) ? '0 : grant_id_q + IW'(1);
  end

`ifdef RR_ARB_TIMEOUT_EN
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] hold_q;
  logic          timeout_q;

  assign expire_c = (hold_q == HW'(MAX_HOLD - 1));

  // Hold counter runs only in GRANT; a forced revoke flags timeout for the GAP cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= (state_q == ST_GRANT) ? hold_q + HW'(1) : '0;
      timeout_q <= (state_q == ST_GRANT) && !release_c && expire_c;
    end
  end

  assign timeout = timeout_q;
`else
  assign expire_c = 1'b0;
  assign timeout  = 1'b0;
`endif

  // Arbitration FSM with registered grant, owner index, pointer and busy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_GAP: begin
          if (pick_any) begin
            state_q    <= ST_GRANT;
            grant_q    <= pick_onehot;
            grant_id_q <= pick_idx;
            busy_q     <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (release_c || expire_c) begin
            state_q <= ST_GAP;
            grant_q <= '0;
            ptr_q   <= ptr_d;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Self-checking bench for rr_resource_arbiter (N=4, MAX_HOLD=8).
module tb_rr_resource_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] grant;
  logic [1:0]   grant_id;
  logic         busy;
  logic         timeout;

  int checks   = 0;
  int failures = 0;

  // Reference model: owner index (-1 = nobody), rotation pointer, last owner, hold count.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_gid   = 0;
  int m_hold  = 0;
  bit m_to    = 1'b0;

  always #5 clk = ~clk;

  rr_resource_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int winner(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge with the given sampled inputs.
  task automatic model_step(input logic [N-1:0] r, input logic d, input logic rst_v);
    int w;
    bit rel;
    if (!rst_v) begin
      m_owner = -1; m_ptr = 0; m_gid = 0; m_hold = 0; m_to = 1'b0;
      return;
    end
    m_to = 1'b0;
    if (m_owner >= 0) begin
      rel = d || !r[m_owner];
      if (rel || (TO_EN && m_hold == MAX_HOLD - 1)) begin
        m_to    = !rel;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_hold++;
      end
    end else begin
      w = winner(r, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_gid = w; m_hold = 0;
      end
    end
  endtask

  // Drive inputs, clock once, then compare every output with the model.
  task automatic cycle(input logic [N-1:0] r, input logic d, input logic rst_v = 1'b1);
    logic [N-1:0] eg;
    req = r; done = d; reset = rst_v;
    model_step(r, d, rst_v);
    @(posedge clk); #1;
    eg = (m_owner >= 0) ? N'(1) << m_owner : '0;
    chk("m_grant", 32'(grant), 32'(eg));
    chk("m_grant_id", 32'(grant_id), 32'(m_gid));
    chk("m_busy", 32'(busy), 32'(m_owner >= 0));
    chk("m_timeout", 32'(timeout), 32'(m_to));
  endtask

  initial begin
    logic [N-1:0] exp_g;
    req = '0; done = 1'b0; reset = 1'b0;

    // Reset then idle with no requests.
    cycle('0, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle('0, 1'b0);
      chk("idle_grant", 32'(grant), 32'h0);
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_gid", 32'(grant_id), 32'h0);
    end

    // req=1010 from ptr 0: grant 1, release, one GAP, then grant 3.
    cycle(4'b1010, 1'b0);
    chk("first_grant", 32'(grant), 32'h2);
    chk("first_gid", 32'(grant_id), 32'h1);
    cycle(4'b1010, 1'b1);
    chk("gap_grant", 32'(grant), 32'h0);
    chk("gap_gid_kept", 32'(grant_id), 32'h1);
    cycle(4'b1010, 1'b0);
    chk("second_grant", 32'(grant), 32'h8);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);

    // All requesting: strict rotation 0,1,2,3,0 with one GAP cycle between.
    for (int k = 0; k < 5; k++) begin
      cycle(4'b1111, 1'b0);
      exp_g = 4'b0001 << (k % 4);
      chk("rot_grant", 32'(grant), 32'(exp_g));
      cycle(4'b1111, 1'b0);
      cycle(4'b1111, 1'b1);
      chk("rot_gap", 32'(grant), 32'h0);
    end
    cycle(4'b0000, 1'b0);

    // Pointer wrap: owner 3 releases, requester 0 is next.
    cycle(4'b1000, 1'b0);
    chk("wrap_owner3", 32'(grant), 32'h8);
    cycle(4'b1001, 1'b1);
    cycle(4'b1001, 1'b0);
    chk("wrap_grant0", 32'(grant), 32'h1);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);

    // Reset during GRANT, then re-grant one cycle after reset releases.
    cycle(4'b0100, 1'b0);
    chk("pre_rst_grant", 32'(grant), 32'h4);
    cycle(4'b0100, 1'b0, 1'b0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_gid", 32'(grant_id), 32'h0);
    cycle(4'b0100, 1'b0);
    chk("post_rst_grant", 32'(grant), 32'h4);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);

`ifdef RR_ARB_TIMEOUT_EN
    // Owner never finishes: revoked after exactly MAX_HOLD cycles.
    cycle(4'b0011, 1'b0);
    chk("to_first", 32'(grant), 32'h1);
    for (int i = 0; i < MAX_HOLD - 1; i++) begin
      cycle(4'b0011, 1'b0);
      chk("to_hold", 32'(grant), 32'h1);
    end
    cycle(4'b0011, 1'b0);
    chk("to_revoke", 32'(grant), 32'h0);
    chk("to_pulse", 32'(timeout), 32'h1);
    cycle(4'b0011, 1'b0);
    chk("to_next", 32'(grant), 32'h2);
    chk("to_pulse_end", 32'(timeout), 32'h0);
    // done on the last allowed cycle wins over the timeout.
    for (int i = 0; i < MAX_HOLD - 1; i++) cycle(4'b0011, 1'b0);
    cycle(4'b0011, 1'b1);
    chk("to_done_wins", 32'(timeout), 32'h0);
    chk("to_done_gap", 32'(grant), 32'h0);
    cycle(4'b0000, 1'b0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] r;
      logic d, rs;
      r  = N'($urandom_range(0, (1 << N) - 1));
      d  = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 49) != 0);
      cycle(r, d, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
